multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MAX_WAIT, default 16: memory/MDU wait-cycle limit before fault; legal range 1..255.
REQ-002 Parameter CNT_W, default $clog2(MAX_WAIT+1): wait-counter width.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Opcode  in  7  instruction opcode from datapath IR; sampled in DECODE.
REQ-006 Funct7  in  7  instruction funct7; sampled in DECODE.
REQ-007 imem_ready / dmem_ready / mdu_done  in  1 each  instruction-memory, data-memory and MDU completion.
REQ-008 imem_req / dmem_req  out  1 each  memory request, level-held until ready.
REQ-009 IRWrite / PCWrite  out  1 each  single-cycle load strobes for IR and PC.
REQ-010 ALUSrc, MemtoReg, Branch, jal, jalr  out  1 each  datapath selects.
REQ-011 ALUOp  out  2  00 load/store, 01 branch, 10 R/I-type, 11 LUI/JAL/JALR.
REQ-012 RegWrite, MemRead, MemWrite  out  1 each  state-gated strobes.
REQ-013 mdu_start  out  1  one-cycle MDU launch pulse.
REQ-014 halt, illegal_instr, mem_err  out  1 each  sticky status flags.
REQ-015 state  out  3  current FSM state encoding, for debug.

Function
REQ-016 States SHALL be FETCH, DECODE, EXEC, MEM, WB, MDU_WAIT, HALT, ERR.
REQ-017 FETCH: imem_req=1; on imem_ready, IRWrite=1 that cycle, next DECODE.
REQ-018 DECODE: latch Opcode/Funct7 into op_q/f7_q; opcode 1111111 -> HALT; opcode outside {0010011,0110011,0000011,0100011,1100011,0110111,1101111,1100111} -> ERR with illegal_instr; else -> EXEC.
REQ-019 Static selects (ALUSrc, MemtoReg, ALUOp, Branch, jal, jalr) SHALL be derived from op_q and driven in EXEC, MEM, WB, MDU_WAIT; 0 in all other states.
REQ-020 ALUSrc=1 for load, store, I-type, LUI, JALR; MemtoReg=1 for load only.
REQ-021 EXEC, one cycle: load/store -> MEM; branch -> FETCH with PCWrite=1; all others -> WB.
REQ-022 MEM: dmem_req=1, MemRead (load) or MemWrite (store) held until dmem_ready; on ready load -> WB, store -> FETCH with PCWrite=1.
REQ-023 WB: RegWrite=1 and PCWrite=1 for exactly one cycle, next FETCH.
REQ-024 PCWrite SHALL pulse exactly once per retired instruction, never in HALT/ERR.
REQ-025 Wait counter cleared on entry to FETCH, MEM, MDU_WAIT; increments each cycle without ready/done; reaching MAX_WAIT -> ERR with mem_err=1.
REQ-026 ready/done asserted in the same cycle the counter reaches MAX_WAIT SHALL win; no fault.
REQ-027 ready/done outside their waiting state SHALL be ignored.
REQ-028 HALT and ERR terminal until reset; all strobes and requests 0 there.
REQ-029 Latencies: R/I-type, LUI, JAL, JALR 4 cycles; branch 3; store 4; load 5 (zero-wait memory).

Reset
REQ-030 reset SHALL force FETCH, counter 0, op_q/f7_q 0, clear halt/illegal_instr/mem_err; all outputs 0 except imem_req=1 the first cycle after reset.
REQ-031 reset mid-operation SHALL abandon the instruction; no strobe issued in the reset cycle.

Configuration
REQ-032 Macro CTRL_MULDIV_EN defined: R-type with f7_q=0000001 SHALL pulse mdu_start in EXEC, enter MDU_WAIT until mdu_done, then WB.
REQ-033 Macro CTRL_MULDIV_EN undefined: mdu_start tied 0, mdu_done ignored, MDU_WAIT unreachable, R-type with Funct7=0000001 -> ERR with illegal_instr.

Structure
REQ-034 Package ctrl_pkg SHALL hold opcode localparams, the state enum and ALUOp encodings.
REQ-035 Sub-module main_decoder SHALL map op_q to the static selects combinationally; FSM and counter stay in multicycle_controller.

Verification
REQ-036 Reset then addi (0010011), zero-wait memories -> IRWrite cycle 1, RegWrite+PCWrite cycle 4, ALUSrc=1, ALUOp=10.
REQ-037 lw with dmem_ready delayed 3 cycles -> MemRead held 4 cycles, MemtoReg=1, RegWrite exactly once, 8 cycles total.
REQ-038 imem_ready never asserted, MAX_WAIT=16 -> ERR after 16 FETCH cycles, mem_err=1, no PCWrite.
REQ-039 Opcode 0000000 -> illegal_instr=1, state ERR; Opcode 1111111 -> halt=1, no further imem_req.
REQ-040 With CTRL_MULDIV_EN, mul (0110011, Funct7 0000001), mdu_done after 5 cycles -> one mdu_start pulse, RegWrite after done; without macro -> illegal_instr=1.
REQ-041 reset asserted during MEM of sw -> MemWrite drops same cycle, FETCH with imem_req=1 next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALUOp encodings, FSM state enum and select bundle for the multicycle controller.
// The optional CTRL_MULDIV_EN macro (see multicycle_controller) does not affect this package.
package ctrl_pkg;

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_HALT   = 7'b1111111;

    localparam logic [OPC_W-1:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_UPPER  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5,
        S_HALT     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       branch;
        logic       jal;
        logic       jalr;
    } sel_t;

    // Opcodes the controller knows how to sequence (HALT is handled separately).
    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_ITYPE, OP_RTYPE, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_LUI, OP_JAL, OP_JALR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational map from the latched opcode to the static datapath selects.
// Independent of the CTRL_MULDIV_EN macro.
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] op,
    output sel_t             sel
);

    always_comb begin
        sel = '0;
        case (op)
            OP_ITYPE: begin
                sel.alu_src = 1'b1;
                sel.alu_op  = ALUOP_ARITH;
            end
            OP_RTYPE: sel.alu_op = ALUOP_ARITH;
            OP_LOAD: begin
                sel.alu_src    = 1'b1;
                sel.mem_to_reg = 1'b1;
                sel.alu_op     = ALUOP_MEM;
            end
            OP_STORE: begin
                sel.alu_src = 1'b1;
                sel.alu_op  = ALUOP_MEM;
            end
            OP_BRANCH: begin
                sel.alu_op = ALUOP_BRANCH;
                sel.branch = 1'b1;
            end
            OP_LUI: begin
                sel.alu_src = 1'b1;
                sel.alu_op  = ALUOP_UPPER;
            end
            OP_JAL: begin
                sel.alu_op = ALUOP_UPPER;
                sel.jal    = 1'b1;
            end
            OP_JALR: begin
                sel.alu_src = 1'b1;
                sel.alu_op  = ALUOP_UPPER;
                sel.jalr    = 1'b1;
            end
            default: sel = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with memory/MDU wait timeout and sticky status flags.
// Optional macro CTRL_MULDIV_EN enables the MDU launch/wait path for R-type funct7=0000001.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] Opcode,
    input  logic [OPC_W-1:0] Funct7,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             mdu_done,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             Branch,
    output logic             jal,
    output logic             jalr,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             mdu_start,
    output logic             halt,
    output logic             illegal_instr,
    output logic             mem_err,
    output logic [2:0]       state
);

    state_t           state_q;
    logic [OPC_W-1:0] op_q;
    logic [OPC_W-1:0] f7_q;
    logic [CNT_W-1:0] cnt_q;
    sel_t             sel;
    logic             wait_expired_c;
    logic             is_mul_c;
    logic             mul_illegal_c;

    main_decoder u_main_decoder (
        .op  (op_q),
        .sel (sel)
    );

    // Last permitted wait cycle: a ready/done seen here still wins.
    assign wait_expired_c = (cnt_q == CNT_W'(MAX_WAIT - 1));

`ifdef CTRL_MULDIV_EN
    assign is_mul_c      = (op_q == OP_RTYPE) && (f7_q == F7_MULDIV);
    assign mul_illegal_c = 1'b0;
`else
    logic unused_muldiv;
    assign unused_muldiv = mdu_done ^ (^f7_q);
    assign is_mul_c      = 1'b0;
    assign mul_illegal_c = (Opcode == OP_RTYPE) && (Funct7 == F7_MULDIV);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            cnt_q         <= '0;
            op_q          <= '0;
            f7_q          <= '0;
            halt          <= 1'b0;
            illegal_instr <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_q <= S_DECODE;
                    end else if (wait_expired_c) begin
                        state_q <= S_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    op_q  <= Opcode;
                    f7_q  <= Funct7;
                    cnt_q <= '0;
                    if (Opcode == OP_HALT) begin
                        state_q <= S_HALT;
                        halt    <= 1'b1;
                    end else if (!is_legal_op(Opcode) || mul_illegal_c) begin
                        state_q       <= S_ERR;
                        illegal_instr <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_q <= '0;
                    if (op_q == OP_LOAD || op_q == OP_STORE) begin
                        state_q <= S_MEM;
                    end else if (op_q == OP_BRANCH) begin
                        state_q <= S_FETCH;
                    end else if (is_mul_c) begin
                        state_q <= S_MDU_WAIT;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        cnt_q   <= '0;
                        state_q <= (op_q == OP_LOAD) ? S_WB : S_FETCH;
                    end else if (wait_expired_c) begin
                        state_q <= S_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WB: begin
                    cnt_q   <= '0;
                    state_q <= S_FETCH;
                end
`ifdef CTRL_MULDIV_EN
                S_MDU_WAIT: begin
                    if (mdu_done) begin
                        cnt_q   <= '0;
                        state_q <= S_WB;
                    end else if (wait_expired_c) begin
                        state_q <= S_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                S_HALT:  state_q <= S_HALT;
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_ERR;
            endcase
        end
    end

    // Strobes and requests decode the current state; reset suppresses all of them.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mdu_start = 1'b0;
        ALUSrc    = 1'b0;
        MemtoReg  = 1'b0;
        ALUOp     = 2'b00;
        Branch    = 1'b0;
        jal       = 1'b0;
        jalr      = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    IRWrite  = imem_ready;
                end
                S_EXEC: begin
                    PCWrite   = (op_q == OP_BRANCH);
                    mdu_start = is_mul_c;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    MemRead  = (op_q == OP_LOAD);
                    MemWrite = (op_q == OP_STORE);
                    PCWrite  = dmem_ready && (op_q == OP_STORE);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                end
                default: ;
            endcase
            if (state_q inside {S_EXEC, S_MEM, S_WB, S_MDU_WAIT}) begin
                ALUSrc   = sel.alu_src;
                MemtoReg = sel.mem_to_reg;
                ALUOp    = sel.alu_op;
                Branch   = sel.branch;
                jal      = sel.jal;
                jalr     = sel.jalr;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed corner cases plus a random instruction stream.
module tb_multicycle_controller;

    localparam int MAX_WAIT = 16;

    localparam logic [6:0] T_ADDI = 7'b0010011, T_ADD = 7'b0110011, T_LW = 7'b0000011,
                           T_SW = 7'b0100011, T_BEQ = 7'b1100011, T_LUI = 7'b0110111,
                           T_JAL = 7'b1101111, T_JALR = 7'b1100111, T_HLT = 7'b1111111;

    localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3, C_MUL = 4, C_HLT = 5, C_ILL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Opcode = '0, Funct7 = '0;
    logic       imem_ready = 1'b0, dmem_ready = 1'b0, mdu_done = 1'b0;
    logic       imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, Branch, jal, jalr;
    logic [1:0] ALUOp;
    logic       RegWrite, MemRead, MemWrite, mdu_start, halt, illegal_instr, mem_err;
    logic [2:0] state;

    int nchk = 0;
    int nerr = 0;

    multicycle_controller #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct7(Funct7),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .mdu_done(mdu_done),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .Branch(Branch), .jal(jal), .jalr(jalr),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .mdu_start(mdu_start), .halt(halt), .illegal_instr(illegal_instr), .mem_err(mem_err),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction class from the opcode/funct7 rules.
    function automatic int cls_of(input logic [6:0] op, input logic [6:0] f7);
        case (op)
            T_ADDI, T_LUI, T_JAL, T_JALR: return C_ALU;
            T_ADD: begin
                if (f7 != 7'b0000001) return C_ALU;
`ifdef CTRL_MULDIV_EN
                return C_MUL;
`else
                return C_ILL;
`endif
            end
            T_LW:    return C_LD;
            T_SW:    return C_ST;
            T_BEQ:   return C_BR;
            T_HLT:   return C_HLT;
            default: return C_ILL;
        endcase
    endfunction

    // Expected {ALUSrc, MemtoReg, ALUOp, Branch, jal, jalr} per opcode.
    function automatic logic [6:0] sel_of(input logic [6:0] op);
        case (op)
            T_ADDI:  return 7'b1_0_10_000;
            T_ADD:   return 7'b0_0_10_000;
            T_LW:    return 7'b1_1_00_000;
            T_SW:    return 7'b1_0_00_000;
            T_BEQ:   return 7'b0_0_01_100;
            T_LUI:   return 7'b1_0_11_000;
            T_JAL:   return 7'b0_0_11_010;
            T_JALR:  return 7'b1_0_11_001;
            default: return 7'b0;
        endcase
    endfunction

    function automatic logic [6:0] sel_now();
        return {ALUSrc, MemtoReg, ALUOp, Branch, jal, jalr};
    endfunction

    function automatic logic [7:0] strobes_now();
        return {imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, mdu_start};
    endfunction

    // Hold reset two cycles; on release only imem_req may be high.
    task automatic do_reset();
        reset = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0; mdu_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_strobes", 32'(strobes_now()), 32'h80);
        chk("reset_sel", 32'(sel_now()), 32'd0);
        chk("reset_flags", 32'({halt, illegal_instr, mem_err}), 32'd0);
    endtask

    // Run one instruction with di fetch waits, dm data waits, dd MDU waits; compare against class rules.
    task automatic run_instr(input logic [6:0] op, input logic [6:0] f7, input int di, input int dm,
                             input int dd);
        int cls, cyc, nir, npc, nrw, nmr, nmw, nms, ireq, dreq, mwait, ir_at, rw_at;
        int exp_cyc, exp_rw, exp_mr, exp_mw, exp_ms, exp_state;
        logic [2:0] exp_flags;
        logic [6:0] sel_seen;
        bit done, term, timeout;
        cls = cls_of(op, f7);
        cyc = 0; nir = 0; npc = 0; nrw = 0; nmr = 0; nmw = 0; nms = 0;
        ireq = 0; dreq = 0; mwait = 0; ir_at = 0; rw_at = 0;
        sel_seen = '0; done = 0; term = 0;
        Opcode = op; Funct7 = f7;
        chk("start_state", 32'(state), 32'd0);
        while (!done && cyc < 300) begin
            if (state == 3'd6 || state == 3'd7) begin
                term = 1; done = 1;
            end else begin
                imem_ready = imem_req ? (ireq == di) : 1'($urandom_range(0, 1));
                dmem_ready = dmem_req ? (dreq == dm) : 1'($urandom_range(0, 1));
                mdu_done   = (state == 3'd5) ? (mwait == dd) : 1'($urandom_range(0, 1));
                #1;
                cyc++;
                if (imem_req) ireq++;
                if (dmem_req) dreq++;
                if (state == 3'd5) mwait++;
                nir += 32'(IRWrite); npc += 32'(PCWrite); nrw += 32'(RegWrite);
                nmr += 32'(MemRead); nmw += 32'(MemWrite); nms += 32'(mdu_start);
                if (IRWrite) begin
                    ir_at = cyc;
                    chk("fetch_sel_zero", 32'(sel_now()), 32'd0);
                end
                if (RegWrite && rw_at == 0) rw_at = cyc;
                if (PCWrite) begin
                    sel_seen = sel_now();
                    done = 1;
                end
                @(negedge clk);
            end
        end
        if (!done) chk("cycle_budget", 32'd0, 32'd1);

        timeout = (di >= MAX_WAIT);
        exp_rw = 0; exp_mr = 0; exp_mw = 0; exp_ms = 0;
        exp_flags = 3'b000; exp_state = 0;
        case (cls)
            C_ALU: begin exp_cyc = di + 4; exp_rw = 1; end
            C_BR:  exp_cyc = di + 3;
            C_LD:  begin exp_cyc = di + dm + 5; exp_rw = 1; exp_mr = dm + 1; end
            C_ST:  begin exp_cyc = di + dm + 4; exp_mw = dm + 1; end
            C_MUL: begin exp_cyc = di + dd + 5; exp_rw = 1; exp_ms = 1; end
            C_HLT: begin exp_cyc = di + 2; exp_flags = 3'b100; exp_state = 6; end
            default: begin exp_cyc = di + 2; exp_flags = 3'b010; exp_state = 7; end
        endcase
        if (timeout) begin
            exp_cyc = MAX_WAIT; exp_rw = 0; exp_mr = 0; exp_mw = 0; exp_ms = 0;
            exp_flags = 3'b001; exp_state = 7;
        end

        chk("latency", 32'(cyc), 32'(exp_cyc));
        chk("terminal", 32'(term), 32'(exp_state != 0));
        chk("irwrite_count", 32'(nir), timeout ? 32'd0 : 32'd1);
        chk("irwrite_cycle", 32'(ir_at), timeout ? 32'd0 : 32'(di + 1));
        chk("pcwrite_count", 32'(npc), (exp_state != 0) ? 32'd0 : 32'd1);
        chk("regwrite_count", 32'(nrw), 32'(exp_rw));
        chk("regwrite_cycle", 32'(rw_at), exp_rw != 0 ? 32'(exp_cyc) : 32'd0);
        chk("memread_cycles", 32'(nmr), 32'(exp_mr));
        chk("memwrite_cycles", 32'(nmw), 32'(exp_mw));
        chk("mdu_start_count", 32'(nms), 32'(exp_ms));
        chk("flags", 32'({halt, illegal_instr, mem_err}), 32'(exp_flags));
        if (exp_state == 0) begin
            chk("retire_sel", 32'(sel_seen), 32'(sel_of(op)));
        end else begin
            chk("end_state", 32'(state), 32'(exp_state));
            // Terminal states must ignore every ready/done and stay silent.
            for (int k = 0; k < 3; k++) begin
                imem_ready = 1'b1; dmem_ready = 1'b1; mdu_done = 1'b1;
                #1;
                chk("terminal_quiet", 32'({strobes_now(), sel_now()}), 32'd0);
                chk("terminal_hold", 32'(state), 32'(exp_state));
                @(negedge clk);
            end
            do_reset();
        end
    endtask

    initial begin
        logic [6:0] ops [10];
        logic [6:0] op, f7;
        ops = '{T_ADDI, T_ADD, T_LW, T_SW, T_BEQ, T_LUI, T_JAL, T_JALR, T_HLT, 7'b0000000};

        @(negedge clk);
        do_reset();

        run_instr(T_ADDI, 7'd0, 0, 0, 0);
        run_instr(T_LW,   7'd0, 0, 3, 0);
        run_instr(T_SW,   7'd0, 1, 2, 0);
        run_instr(T_BEQ,  7'd0, 2, 0, 0);
        run_instr(T_LUI,  7'd0, 0, 0, 0);
        run_instr(T_JAL,  7'd0, 0, 0, 0);
        run_instr(T_JALR, 7'd0, 1, 0, 0);
        run_instr(T_ADD,  7'b0100000, 0, 0, 0);
        run_instr(T_ADDI, 7'd0, MAX_WAIT - 1, 0, 0);
        run_instr(T_LW,   7'd0, 0, MAX_WAIT - 1, 0);
        run_instr(T_ADDI, 7'd0, MAX_WAIT + 4, 0, 0);
        run_instr(7'b0000000, 7'd0, 0, 0, 0);
        run_instr(T_HLT,  7'd0, 0, 0, 0);
        run_instr(T_ADD,  7'b0000001, 0, 0, 5);

        // Reset while a store waits in MEM abandons it without a strobe.
        Opcode = T_SW; Funct7 = 7'd0;
        imem_ready = 1'b1; dmem_ready = 1'b0; mdu_done = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sw_in_mem", 32'(state), 32'd3);
        chk("sw_memwrite", 32'({MemWrite, dmem_req}), 32'd3);
        reset = 1'b1;
        #1;
        chk("reset_drops_strobes", 32'(strobes_now()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_reset_fetch", 32'({state, imem_req}), 32'({3'd0, 1'b1}));
        chk("after_reset_flags", 32'({halt, illegal_instr, mem_err}), 32'd0);

        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) op = 7'($urandom);
            f7 = 7'd0;
            if (op == T_ADD) begin
                case ($urandom_range(0, 2))
                    0: f7 = 7'd0;
                    1: f7 = 7'b0100000;
                    default: f7 = 7'b0000001;
                endcase
            end
            run_instr(op, f7, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
